// File: rtl/rename_unit.sv
// Register-rename stage: RAT, ready scoreboard and a circular physical-register free list
// feeding a one-entry registered output toward dispatch.
module rename_unit #(
  parameter  int PHYS_REGS    = 32,
  parameter  int FIXED_REGS   = 2,
  parameter  int RENAMED_REGS = 10,
  localparam int PW           = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_microop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_microop,
  output logic [4*PW-1:0]   out_src_regs,
  output logic [3:0]        out_src_ready,
  output logic [3:0]        out_imm,
  output logic [2*PW-1:0]   out_dst_regs,
  output logic [1:0]        out_dst_valid,
  output logic [2*PW-1:0]   out_old_dst,
  input  logic              wb_valid,
  input  logic [PW-1:0]     wb_reg,
  input  logic [1:0]        free_valid,
  input  logic [2*PW-1:0]   free_reg
);

  localparam logic [3:0] FIXED_A = 4'(FIXED_REGS);

  logic [PW-1:0]  r_rat [16];
  logic [PHYS_REGS-1:0] r_sb;
  logic [PW-1:0]  r_fl [PHYS_REGS];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [PW:0]    r_count;

  logic [3:0]     w_opc;
  logic [15:0]    w_src_arch;
  logic [3:0]     w_imm;
  logic [3:0]     w_dst0_arch, w_dst1_arch;
  logic           w_dst0_raw, w_dst1_raw;
  logic           w_dst0_v, w_dst1_v;
  logic [1:0]     w_ndst;
  logic           w_accept;
  logic [PW-1:0]  w_new0, w_new1, w_old0, w_old1;
  logic [4*PW-1:0] w_src_regs;
  logic [3:0]     w_src_ready;
  logic [1:0]     w_pop, w_push;

  assign w_opc = in_microop[23:20];

  always_comb begin
    w_src_arch = {4'h0, in_microop[11:0]};
    w_imm      = 4'h0;
    case (w_opc)
      4'b1011: begin w_src_arch = {4'h0, in_microop[11:4], 4'h0};           w_imm = in_microop[3:0];   end
      4'b1100: begin w_src_arch = {4'h0, in_microop[11:0]};                 w_imm = in_microop[19:16]; end
      4'b1101: begin w_src_arch = in_microop[15:0];                         w_imm = in_microop[19:16]; end
      4'b1110: begin w_src_arch = {in_microop[15:4], in_microop[19:16]};   w_imm = in_microop[3:0];   end
      4'b1111: begin w_src_arch = {in_microop[15:12], 8'h00, in_microop[19:16]}; w_imm = in_microop[3:0]; end
      default: ;
    endcase
  end

  always_comb begin
    w_dst0_arch = in_microop[19:16];
    w_dst1_arch = in_microop[15:12];
    w_dst0_raw  = 1'b0;
    w_dst1_raw  = 1'b0;
    if (w_opc <= 4'b1010) begin
      w_dst0_raw = 1'b1;
      w_dst1_raw = 1'b1;
    end else if (w_opc == 4'b1011 || w_opc == 4'b1100) begin
      w_dst0_arch = in_microop[15:12];
      w_dst0_raw  = 1'b1;
    end
  end

  // Destinations naming a hardwired register are dropped and never allocate.
  assign w_dst0_v = w_dst0_raw && (w_dst0_arch >= FIXED_A);
  assign w_dst1_v = w_dst1_raw && (w_dst1_arch >= FIXED_A);
  assign w_ndst   = {1'b0, w_dst0_v} + {1'b0, w_dst1_v};

  assign in_ready = (!out_valid || out_ready) && (r_count >= {{(PW-1){1'b0}}, w_ndst});
  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_src
    logic [3:0]    w_a;
    logic [PW-1:0] w_p;
    assign w_a = w_src_arch[4*k +: 4];
    assign w_p = (w_a < FIXED_A) ? PW'(w_a) : r_rat[w_a];
    assign w_src_regs[k*PW +: PW] = w_p;
    assign w_src_ready[k] = (w_a < FIXED_A) || r_sb[w_p] || (wb_valid && wb_reg == w_p);
  end

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign w_new0 = r_fl[r_head];
  assign w_new1 = r_fl[r_head + PW'(w_dst0_v)];
  assign w_old0 = r_rat[w_dst0_arch];
  assign w_old1 = (w_dst0_v && w_dst0_arch == w_dst1_arch) ? w_new0 : r_rat[w_dst1_arch];

  assign w_pop  = w_accept ? w_ndst : 2'd0;
  assign w_push = {1'b0, free_valid[0]} + {1'b0, free_valid[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_rat[i] <= PW'(i);
      r_sb <= '1;
      for (int i = 0; i < PHYS_REGS; i++) r_fl[i] <= PW'(FIXED_REGS + RENAMED_REGS + i);
      r_head        <= '0;
      r_tail        <= PW'(PHYS_REGS - FIXED_REGS - RENAMED_REGS);
      r_count       <= (PW+1)'(PHYS_REGS - FIXED_REGS - RENAMED_REGS);
      out_valid     <= 1'b0;
      out_microop   <= '0;
      out_src_regs  <= '0;
      out_src_ready <= '0;
      out_imm       <= '0;
      out_dst_regs  <= '0;
      out_dst_valid <= '0;
      out_old_dst   <= '0;
    end else begin
      if (wb_valid) r_sb[wb_reg] <= 1'b1;
      // Allocation updates come after the writeback so they win on a collision.
      if (w_accept && w_dst0_v) begin
        r_rat[w_dst0_arch] <= w_new0;
        r_sb[w_new0]       <= 1'b0;
      end
      if (w_accept && w_dst1_v) begin
        r_rat[w_dst1_arch] <= w_new1;
        r_sb[w_new1]       <= 1'b0;
      end
      if (free_valid[0]) r_fl[r_tail] <= free_reg[PW-1:0];
      if (free_valid[1]) r_fl[r_tail + PW'(free_valid[0])] <= free_reg[2*PW-1:PW];
      r_tail  <= r_tail + PW'(w_push);
      r_head  <= r_head + PW'(w_pop);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

      if (w_accept) begin
        out_valid     <= 1'b1;
        out_microop   <= in_microop;
        out_src_regs  <= w_src_regs;
        out_src_ready <= w_src_ready;
        out_imm       <= w_imm;
        out_dst_regs  <= {w_dst1_v ? w_new1 : '0, w_dst0_v ? w_new0 : '0};
        out_dst_valid <= {w_dst1_v, w_dst0_v};
        out_old_dst   <= {w_dst1_v ? w_old1 : '0, w_dst0_v ? w_old0 : '0};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: reset defaults, renaming, scoreboard bypass,
// free-list exhaustion, output stall, duplicate destinations and mid-stream reset.
module tb_rename_unit;
  localparam int PW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [23:0]     in_microop = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [23:0]     out_microop;
  logic [4*PW-1:0] out_src_regs;
  logic [3:0]      out_src_ready;
  logic [3:0]      out_imm;
  logic [2*PW-1:0] out_dst_regs;
  logic [1:0]      out_dst_valid;
  logic [2*PW-1:0] out_old_dst;
  logic            wb_valid = 1'b0;
  logic [PW-1:0]   wb_reg = '0;
  logic [1:0]      free_valid = '0;
  logic [2*PW-1:0] free_reg = '0;

  int checks = 0;
  int errors = 0;

  rename_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_microop(in_microop),
    .out_valid(out_valid), .out_ready(out_ready), .out_microop(out_microop),
    .out_src_regs(out_src_regs), .out_src_ready(out_src_ready), .out_imm(out_imm),
    .out_dst_regs(out_dst_regs), .out_dst_valid(out_dst_valid), .out_old_dst(out_old_dst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .free_valid(free_valid), .free_reg(free_reg)
  );

  always #5 clk = ~clk;

  // Free list must never hold more than PHYS_REGS - FIXED_REGS entries.
  always @(negedge clk) begin
    if (!rst && dut.r_count > 6'd30) begin
      $display("FAIL free_list_overflow count=%0d limit=30", dut.r_count);
      errors++;
    end
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; free_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [23:0] op);
    in_valid = 1'b1; in_microop = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_microop = 24'h000000;
    #1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (out_microop !== 24'h0) begin $display("FAIL reset_out_microop got=%h exp=0", out_microop); errors++; end
    checks++; if (out_dst_valid !== 2'b00) begin $display("FAIL reset_dst_valid got=%b exp=00", out_dst_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b exp=1", in_ready); errors++; end
    checks++; if (dut.r_count !== 6'd20) begin $display("FAIL reset_count got=%0d exp=20", dut.r_count); errors++; end
  endtask

  task automatic test_basic();
    do_reset();
    send(24'h045321);
    checks++; if (out_valid !== 1'b1) begin $display("FAIL basic_valid got=%b exp=1", out_valid); errors++; end
    checks++; if (out_src_regs !== {5'd0, 5'd3, 5'd2, 5'd1}) begin $display("FAIL basic_src_regs got=%h exp=%h", out_src_regs, {5'd0, 5'd3, 5'd2, 5'd1}); errors++; end
    checks++; if (out_src_ready !== 4'b1111) begin $display("FAIL basic_src_ready got=%b exp=1111", out_src_ready); errors++; end
    checks++; if (out_dst_regs !== {5'd13, 5'd12}) begin $display("FAIL basic_dst_regs got=%h exp=%h", out_dst_regs, {5'd13, 5'd12}); errors++; end
    checks++; if (out_dst_valid !== 2'b11) begin $display("FAIL basic_dst_valid got=%b exp=11", out_dst_valid); errors++; end
    checks++; if (out_old_dst !== {5'd5, 5'd4}) begin $display("FAIL basic_old_dst got=%h exp=%h", out_old_dst, {5'd5, 5'd4}); errors++; end
    checks++; if (out_imm !== 4'h0) begin $display("FAIL basic_imm got=%h exp=0", out_imm); errors++; end
  endtask

  task automatic test_scoreboard();
    send(24'h000004);
    checks++; if (out_src_regs[4:0] !== 5'd12) begin $display("FAIL sb_dep_reg got=%0d exp=12", out_src_regs[4:0]); errors++; end
    checks++; if (out_src_ready[0] !== 1'b0) begin $display("FAIL sb_dep_notready got=%b exp=0", out_src_ready[0]); errors++; end
    checks++; if (out_dst_valid !== 2'b00) begin $display("FAIL sb_fixed_dst_dropped got=%b exp=00", out_dst_valid); errors++; end
    wb_valid = 1'b1; wb_reg = 5'd12;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    send(24'h000004);
    checks++; if (out_src_ready[0] !== 1'b1) begin $display("FAIL sb_after_wb got=%b exp=1", out_src_ready[0]); errors++; end
    wb_valid = 1'b1; wb_reg = 5'd13;
    send(24'h000005);
    wb_valid = 1'b0;
    checks++; if (out_src_regs[4:0] !== 5'd13) begin $display("FAIL sb_bypass_reg got=%0d exp=13", out_src_regs[4:0]); errors++; end
    checks++; if (out_src_ready[0] !== 1'b1) begin $display("FAIL sb_bypass_ready got=%b exp=1", out_src_ready[0]); errors++; end
  endtask

  task automatic test_freelist_drain();
    do_reset();
    for (int i = 0; i < 10; i++) send(24'h023000);
    checks++; if (out_dst_regs !== {5'd31, 5'd30}) begin $display("FAIL drain_last_alloc got=%h exp=%h", out_dst_regs, {5'd31, 5'd30}); errors++; end
    in_valid = 1'b1; in_microop = 24'hB03000; #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL drain_blocked got=%b exp=0", in_ready); errors++; end
    in_microop = 24'hD12345; #1;
    checks++; if (in_ready !== 1'b1) begin $display("FAIL drain_store_ready got=%b exp=1", in_ready); errors++; end
    @(posedge clk); #1;
    checks++; if (out_src_regs !== {5'd30, 5'd31, 5'd4, 5'd5}) begin $display("FAIL drain_store_src got=%h exp=%h", out_src_regs, {5'd30, 5'd31, 5'd4, 5'd5}); errors++; end
    checks++; if (out_imm !== 4'h1) begin $display("FAIL drain_store_imm got=%h exp=1", out_imm); errors++; end
    in_microop = 24'hB03000; free_valid = 2'b01; free_reg = {5'd0, 5'd21}; #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL drain_push_same_cycle got=%b exp=0", in_ready); errors++; end
    @(posedge clk); #1;
    free_valid = 2'b00;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL drain_not_accepted got=%b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL drain_resume_ready got=%b exp=1", in_ready); errors++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_dst_regs[4:0] !== 5'd21 || out_dst_valid !== 2'b01) begin $display("FAIL drain_resume_alloc got=%0d/%b exp=21/01", out_dst_regs[4:0], out_dst_valid); errors++; end
    checks++; if (out_old_dst[4:0] !== 5'd31) begin $display("FAIL drain_resume_old got=%0d exp=31", out_old_dst[4:0]); errors++; end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    send(24'h045321);
    in_valid = 1'b1; in_microop = 24'h000004;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); errors++; end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_microop !== 24'h045321 || out_dst_regs !== {5'd13, 5'd12} || out_old_dst !== {5'd5, 5'd4}) begin
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=1/045321/%h", i, out_valid, out_microop, out_dst_regs, {5'd13, 5'd12}); errors++;
      end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin $display("FAIL stall_release_ready got=%b exp=1", in_ready); errors++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_microop !== 24'h000004 || out_src_regs[4:0] !== 5'd12 || out_src_ready[0] !== 1'b0) begin
      $display("FAIL stall_next_op got=%h/%0d/%b exp=000004/12/0", out_microop, out_src_regs[4:0], out_src_ready[0]); errors++;
    end
  endtask

  task automatic test_same_dst();
    do_reset();
    send(24'h066000);
    checks++; if (out_dst_regs !== {5'd13, 5'd12}) begin $display("FAIL samedst_regs got=%h exp=%h", out_dst_regs, {5'd13, 5'd12}); errors++; end
    checks++; if (out_old_dst !== {5'd12, 5'd6}) begin $display("FAIL samedst_old got=%h exp=%h", out_old_dst, {5'd12, 5'd6}); errors++; end
    send(24'h000006);
    checks++; if (out_src_regs[4:0] !== 5'd13) begin $display("FAIL samedst_rat got=%0d exp=13", out_src_regs[4:0]); errors++; end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(24'h045321);
    rst = 1'b1; in_valid = 1'b1; in_microop = 24'h0AB000;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL midrst_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (dut.r_count !== 6'd20) begin $display("FAIL midrst_count got=%0d exp=20", dut.r_count); errors++; end
    send(24'h000004);
    checks++; if (out_src_regs[4:0] !== 5'd4 || out_src_ready[0] !== 1'b1) begin
      $display("FAIL midrst_rat got=%0d/%b exp=4/1", out_src_regs[4:0], out_src_ready[0]); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scoreboard();
    test_freelist_drain();
    test_stall();
    test_same_dst();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
